// File: rtl/snn_pkg.sv
// Shared FSM encoding and default sizing for the SNN layer scheduler and its counters.
package snn_pkg;

    localparam int DEF_N_NEURON    = 8;
    localparam int DEF_ENCODE_TIME = 23;
    localparam int DEF_CW          = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SCAN,
        S_DONE
    } state_t;

    // Index width that stays legal when a dimension collapses to a single entry.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/snn_spike_counter.sv
// One saturating per-neuron spike counter with synchronous clear and count enable.
module snn_spike_counter
    import snn_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    input  logic          spike,
    output logic [CW-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && spike && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/snn_layer_scheduler.sv
// Sequences one SNN sample: clear, ENCODE_TIME run steps with lateral inhibition,
// a one-counter-per-cycle winner scan, and a single-cycle result strobe.
module snn_layer_scheduler
    import snn_pkg::*;
#(
    parameter int N_NEURON    = DEF_N_NEURON,
    parameter int ENCODE_TIME = DEF_ENCODE_TIME,
    parameter int CW          = DEF_CW
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    output logic                                busy,
    output logic                                neuron_rst,
    output logic                                neuron_en,
    output logic [clog2_min1(ENCODE_TIME)-1:0]  step,
    input  logic [N_NEURON-1:0]                 spikes,
    output logic [N_NEURON-1:0]                 inh,
    output logic                                result_valid,
    output logic [clog2_min1(N_NEURON)-1:0]     result_idx,
    output logic [CW-1:0]                       result_cnt,
    output logic                                result_none
);

    localparam int SW = clog2_min1(ENCODE_TIME);
    localparam int IW = clog2_min1(N_NEURON);

    state_t        state;
    logic [IW-1:0] scan_idx;
    logic [IW-1:0] best_idx;
    logic [CW-1:0] best_cnt;
    logic [CW-1:0] cnt [N_NEURON];

    logic [IW-1:0]       win_idx;
    logic [N_NEURON-1:0] inh_next;
    logic [CW-1:0]       cnt_sel;
    logic [IW-1:0]       nbest_idx;
    logic [CW-1:0]       nbest_cnt;
    logic                last_step;
    logic                last_scan;

    // Counters clear whenever neuron_rst is high and count only while neuron_en is high,
    // so they track the registered neuron-array controls exactly.
    for (genvar g = 0; g < N_NEURON; g++) begin : g_cnt
        snn_spike_counter #(.CW(CW)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (neuron_rst),
            .en    (neuron_en),
            .spike (spikes[g]),
            .count (cnt[g])
        );
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win_idx = '0;
        for (int i = N_NEURON - 1; i >= 0; i--) begin
            if (spikes[i]) win_idx = IW'(i);
        end
        inh_next  = ~(N_NEURON'(1) << win_idx);
        cnt_sel   = cnt[scan_idx];
        nbest_idx = best_idx;
        nbest_cnt = best_cnt;
        if (cnt_sel > best_cnt) begin
            nbest_idx = scan_idx;
            nbest_cnt = cnt_sel;
        end
        last_step = (step == SW'(ENCODE_TIME - 1));
        last_scan = (scan_idx == IW'(N_NEURON - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            neuron_rst   <= 1'b1;
            neuron_en    <= 1'b0;
            step         <= '0;
            inh          <= '0;
            result_valid <= 1'b0;
            result_idx   <= '0;
            result_cnt   <= '0;
            result_none  <= 1'b0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best_cnt     <= '0;
        end else begin
            neuron_rst   <= 1'b0;
            result_valid <= 1'b0;
            inh          <= '0;
            if (abort && (state inside {S_CLEAR, S_RUN, S_SCAN})) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                neuron_rst <= 1'b1;
                neuron_en  <= 1'b0;
                step       <= '0;
                scan_idx   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state      <= S_CLEAR;
                            busy       <= 1'b1;
                            neuron_rst <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        state     <= S_RUN;
                        neuron_en <= 1'b1;
                        step      <= '0;
                        best_idx  <= '0;
                        best_cnt  <= '0;
                    end
                    S_RUN: begin
                        // Inhibition from the final step would land in SCAN, so it is dropped.
                        if ((spikes != '0) && !last_step) inh <= inh_next;
                        if (last_step) begin
                            state     <= S_SCAN;
                            neuron_en <= 1'b0;
                            step      <= '0;
                            scan_idx  <= '0;
                        end else begin
                            step <= step + SW'(1);
                        end
                    end
                    S_SCAN: begin
                        best_idx <= nbest_idx;
                        best_cnt <= nbest_cnt;
                        if (last_scan) begin
                            state        <= S_DONE;
                            result_valid <= 1'b1;
                            result_idx   <= nbest_idx;
                            result_cnt   <= nbest_cnt;
                            result_none  <= (nbest_cnt == '0);
                        end else begin
                            scan_idx <= scan_idx + IW'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snn_layer_scheduler.sv
// Bench for snn_layer_scheduler: directed and random spike patterns against a
// count/argmax reference model, with a CW=4 copy sharing the stimulus for saturation.
module tb_snn_layer_scheduler;
    import snn_pkg::*;

    localparam int N  = DEF_N_NEURON;
    localparam int T  = DEF_ENCODE_TIME;
    localparam int SW = clog2_min1(T);
    localparam int IW = clog2_min1(N);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] spikes = '0;

    logic          busy_a, neuron_rst_a, neuron_en_a, result_valid_a, result_none_a;
    logic [SW-1:0] step_a;
    logic [N-1:0]  inh_a;
    logic [IW-1:0] result_idx_a;
    logic [7:0]    result_cnt_a;

    logic          busy_b, neuron_rst_b, neuron_en_b, result_valid_b, result_none_b;
    logic [SW-1:0] step_b;
    logic [N-1:0]  inh_b;
    logic [IW-1:0] result_idx_b;
    logic [3:0]    result_cnt_b;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] pat [T];
    int exp_idx_a, exp_cnt_a, exp_none_a;
    int exp_idx_b, exp_cnt_b, exp_none_b;

    snn_layer_scheduler #(.N_NEURON(N), .ENCODE_TIME(T), .CW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy_a), .neuron_rst(neuron_rst_a), .neuron_en(neuron_en_a), .step(step_a),
        .spikes(spikes), .inh(inh_a), .result_valid(result_valid_a),
        .result_idx(result_idx_a), .result_cnt(result_cnt_a), .result_none(result_none_a)
    );

    snn_layer_scheduler #(.N_NEURON(N), .ENCODE_TIME(T), .CW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy_b), .neuron_rst(neuron_rst_b), .neuron_en(neuron_en_b), .step(step_b),
        .spikes(spikes), .inh(inh_b), .result_valid(result_valid_b),
        .result_idx(result_idx_b), .result_cnt(result_cnt_b), .result_none(result_none_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inhibit everything except the lowest-numbered spiking neuron.
    function automatic logic [N-1:0] exp_inh(input logic [N-1:0] p);
        logic [N-1:0] low;
        low = p & (~p + 1'b1);
        return (p == '0) ? '0 : ~low;
    endfunction

    task automatic compute_expected();
        int sum;
        int ca [N];
        int cb [N];
        int max_a, max_b;
        max_a = 0;
        max_b = 0;
        for (int i = 0; i < N; i++) begin
            sum = 0;
            for (int s = 0; s < T; s++) sum += int'(pat[s][i]);
            ca[i] = (sum > 255) ? 255 : sum;
            cb[i] = (sum > 15) ? 15 : sum;
            if (ca[i] > max_a) max_a = ca[i];
            if (cb[i] > max_b) max_b = cb[i];
        end
        exp_idx_a = -1;
        exp_idx_b = -1;
        for (int i = 0; i < N; i++) begin
            if (exp_idx_a < 0 && ca[i] == max_a) exp_idx_a = i;
            if (exp_idx_b < 0 && cb[i] == max_b) exp_idx_b = i;
        end
        exp_cnt_a  = max_a;
        exp_cnt_b  = max_b;
        exp_none_a = (max_a == 0) ? 1 : 0;
        exp_none_b = (max_b == 0) ? 1 : 0;
    endtask

    task automatic clear_pat();
        for (int s = 0; s < T; s++) pat[s] = '0;
    endtask

    // Start sample at cycle 0; CLEAR is cycle 1, RUN cycles 2..T+1, SCAN T+2..T+N+1, DONE T+N+2.
    task automatic run_sample(input string name, input int abort_at);
        logic [N-1:0] prev;
        logic         rv_seen;
        compute_expected();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({name, ":clear_busy"}, 32'(busy_a), 32'd1);
        check({name, ":clear_nrst"}, 32'(neuron_rst_a), 32'd1);
        check({name, ":clear_en"}, 32'(neuron_en_a), 32'd0);
        prev = '0;
        for (int s = 0; s < T; s++) begin
            @(negedge clk);
            check({name, ":run_en"}, 32'(neuron_en_a), 32'd1);
            check({name, ":run_step"}, 32'(step_a), 32'(s));
            check({name, ":run_inh"}, 32'(inh_a), 32'(exp_inh(prev)));
            check({name, ":run_inh_b"}, 32'(inh_b), 32'(exp_inh(prev)));
            if (s == abort_at) begin
                abort = 1'b1;
                spikes = pat[s];
                @(negedge clk);
                abort = 1'b0;
                spikes = '0;
                check({name, ":abort_nrst"}, 32'(neuron_rst_a), 32'd1);
                check({name, ":abort_busy"}, 32'(busy_a), 32'd0);
                check({name, ":abort_inh"}, 32'(inh_a), 32'd0);
                check({name, ":abort_en"}, 32'(neuron_en_a), 32'd0);
                rv_seen = result_valid_a | result_valid_b;
                @(negedge clk);
                check({name, ":abort_nrst_1cyc"}, 32'(neuron_rst_a), 32'd0);
                for (int k = 0; k < T + N + 8; k++) begin
                    rv_seen |= result_valid_a | result_valid_b;
                    @(negedge clk);
                end
                check({name, ":abort_no_rv"}, 32'(rv_seen), 32'd0);
                check({name, ":abort_idle_busy"}, 32'(busy_a), 32'd0);
                return;
            end
            spikes = pat[s];
            prev   = pat[s];
        end
        @(negedge clk);
        spikes = '0;
        check({name, ":scan_inh"}, 32'(inh_a), 32'd0);
        check({name, ":scan_en"}, 32'(neuron_en_a), 32'd0);
        check({name, ":scan_busy"}, 32'(busy_a), 32'd1);
        rv_seen = result_valid_a;
        repeat (N - 1) begin
            @(negedge clk);
            rv_seen |= result_valid_a;
        end
        check({name, ":scan_no_rv"}, 32'(rv_seen), 32'd0);
        @(negedge clk);
        check({name, ":done_rv"}, 32'(result_valid_a), 32'd1);
        check({name, ":done_idx"}, 32'(result_idx_a), 32'(exp_idx_a));
        check({name, ":done_cnt"}, 32'(result_cnt_a), 32'(exp_cnt_a));
        check({name, ":done_none"}, 32'(result_none_a), 32'(exp_none_a));
        check({name, ":done_rv_b"}, 32'(result_valid_b), 32'd1);
        check({name, ":done_idx_b"}, 32'(result_idx_b), 32'(exp_idx_b));
        check({name, ":done_cnt_b"}, 32'(result_cnt_b), 32'(exp_cnt_b));
        @(negedge clk);
        check({name, ":post_rv"}, 32'(result_valid_a), 32'd0);
        check({name, ":post_busy"}, 32'(busy_a), 32'd0);
        check({name, ":post_idx_held"}, 32'(result_idx_a), 32'(exp_idx_a));
        check({name, ":post_cnt_held"}, 32'(result_cnt_a), 32'(exp_cnt_a));
    endtask

    task automatic check_reset_values(input string name);
        check({name, ":busy"}, 32'(busy_a), 32'd0);
        check({name, ":nrst"}, 32'(neuron_rst_a), 32'd1);
        check({name, ":en"}, 32'(neuron_en_a), 32'd0);
        check({name, ":step"}, 32'(step_a), 32'd0);
        check({name, ":inh"}, 32'(inh_a), 32'd0);
        check({name, ":rv"}, 32'(result_valid_a), 32'd0);
        check({name, ":idx"}, 32'(result_idx_a), 32'd0);
        check({name, ":cnt"}, 32'(result_cnt_a), 32'd0);
        check({name, ":none"}, 32'(result_none_a), 32'd0);
        check({name, ":cnt_b"}, 32'(result_cnt_b), 32'd0);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_nrst", 32'(neuron_rst_a), 32'd0);
        check("reset_release_busy", 32'(busy_a), 32'd0);

        // Single spike from neuron 2 at step 5
        clear_pat();
        pat[5] = 8'h04;
        run_sample("single", -1);

        // Tie between neurons 3 and 6
        clear_pat();
        pat[1] = 8'h48; pat[4] = 8'h48; pat[7] = 8'h48; pat[10] = 8'h48;
        run_sample("tie", -1);

        // Simultaneous 0x81, then extra neuron-7 spikes show its counter advanced too
        clear_pat();
        pat[3] = 8'h81;
        run_sample("simul", -1);
        clear_pat();
        pat[3] = 8'h81; pat[8] = 8'h80; pat[12] = 8'h80;
        run_sample("simul7", -1);

        // Silent sample
        clear_pat();
        run_sample("none", -1);

        // Neuron 0 fires every step, including the last one
        for (int s = 0; s < T; s++) pat[s] = 8'h01;
        run_sample("saturate", -1);

        // Random sparse activity
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < T; s++)
                pat[s] = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            run_sample($sformatf("rand%0d", k), -1);
        end

        // Abort mid-RUN, then a clean sample
        for (int s = 0; s < T; s++) pat[s] = N'($urandom);
        run_sample("abort", 10);
        clear_pat();
        pat[1] = 8'h48; pat[4] = 8'h48; pat[7] = 8'h48; pat[10] = 8'h48;
        run_sample("after_abort", -1);

        // Asynchronous reset in the middle of RUN
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) begin
            @(negedge clk);
            spikes = 8'hff;
        end
        @(negedge clk);
        rst_n = 1'b0;
        spikes = '0;
        #1;
        check_reset_values("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrun_release_nrst", 32'(neuron_rst_a), 32'd0);
        check("midrun_release_busy", 32'(busy_a), 32'd0);
        clear_pat();
        pat[5] = 8'h04;
        run_sample("after_reset", -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
